// File: rtl/sccb_master_if.sv
// Request/response bundle between a configuration sequencer and the SCCB engine.
// With SCCB_ACK_CHECK_EN defined the bundle also carries the sticky nack flag.
interface sccb_master_if #(
    parameter int ADDR_W = 8
);
    logic              start;
    logic              rw;
    logic [6:0]        dev_id;
    logic [ADDR_W-1:0] sub_addr;
    logic [7:0]        wr_data;
    logic [7:0]        rd_data;
    logic              busy;
    logic              done;
`ifdef SCCB_ACK_CHECK_EN
    logic              nack;
`endif

    // Sequencer side: issues requests and watches completion.
    modport master (
        output start, rw, dev_id, sub_addr, wr_data,
`ifdef SCCB_ACK_CHECK_EN
        input  nack,
`endif
        input  rd_data, busy, done
    );

    // Engine side: accepts requests and reports completion.
    modport slave (
        input  start, rw, dev_id, sub_addr, wr_data,
`ifdef SCCB_ACK_CHECK_EN
        output nack,
`endif
        output rd_data, busy, done
    );
endinterface

// File: rtl/sccb_master.sv
// SCCB register write / read engine driving SIO_C and open-drain SIO_D.
// Optional SCCB_ACK_CHECK_EN: sample the 9th bit of master-written bytes, abort with nack on a 1.
module sccb_master #(
    parameter int CLK_DIV = 100,
    parameter int ADDR_W  = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    sccb_master_if.slave cfg,
    output logic         sio_c,
    inout  wire          sio_d
);
    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int NBYTES = ADDR_W / 8;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    typedef enum logic [3:0] {
        IDLE, START, ID, SUBADDR, WDATA, STOP, RSTART, RID, RDATA, DONE
    } state_t;

    state_t            state_reg, state_next;
    logic [DIV_W-1:0]  div_reg, div_next;
    logic [1:0]        qtr_reg, qtr_next;
    logic [3:0]        bit_reg, bit_next;
    logic              byte_reg, byte_next;
    logic              rw_reg, rw_next;
    logic [6:0]        id_reg, id_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [7:0]        wdat_reg, wdat_next;
    logic [7:0]        rx_reg, rx_next;
    logic [7:0]        rd_data_reg, rd_data_next;
    logic              samp_reg, samp_next;
    logic              rd_phase_reg, rd_phase_next;
    logic              nack_reg, nack_next;
    logic              c_reg, c_next;
    logic              d_reg, d_next;
    logic              busy_reg, busy_next;
    logic              done_reg, done_next;
    logic [1:0]        sync_reg;
    logic              tick, slot_end;
    logic [7:0]        tx_byte;
    logic              tx_bit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            div_reg      <= '0;
            qtr_reg      <= 2'd0;
            bit_reg      <= 4'd0;
            byte_reg     <= 1'b0;
            rw_reg       <= 1'b0;
            id_reg       <= 7'd0;
            addr_reg     <= '0;
            wdat_reg     <= 8'd0;
            rx_reg       <= 8'd0;
            rd_data_reg  <= 8'd0;
            samp_reg     <= 1'b1;
            rd_phase_reg <= 1'b0;
            nack_reg     <= 1'b0;
            c_reg        <= 1'b1;
            d_reg        <= 1'b1;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            sync_reg     <= 2'b11;
        end else begin
            state_reg    <= state_next;
            div_reg      <= div_next;
            qtr_reg      <= qtr_next;
            bit_reg      <= bit_next;
            byte_reg     <= byte_next;
            rw_reg       <= rw_next;
            id_reg       <= id_next;
            addr_reg     <= addr_next;
            wdat_reg     <= wdat_next;
            rx_reg       <= rx_next;
            rd_data_reg  <= rd_data_next;
            samp_reg     <= samp_next;
            rd_phase_reg <= rd_phase_next;
            nack_reg     <= nack_next;
            c_reg        <= c_next;
            d_reg        <= d_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
            sync_reg     <= {sync_reg[0], sio_d};
        end
    end

    assign tick     = (div_reg == DIV_LAST);
    assign slot_end = tick && (qtr_reg == 2'd3);

    always_comb begin
        state_next    = state_reg;
        div_next      = div_reg;
        qtr_next      = qtr_reg;
        bit_next      = bit_reg;
        byte_next     = byte_reg;
        rw_next       = rw_reg;
        id_next       = id_reg;
        addr_next     = addr_reg;
        wdat_next     = wdat_reg;
        rx_next       = rx_reg;
        rd_data_next  = rd_data_reg;
        samp_next     = samp_reg;
        rd_phase_next = rd_phase_reg;
        nack_next     = nack_reg;

        case (state_reg)
            IDLE: begin
                if (cfg.start) begin
                    rw_next       = cfg.rw;
                    id_next       = cfg.dev_id;
                    addr_next     = cfg.sub_addr;
                    wdat_next     = cfg.wr_data;
                    state_next    = START;
                    div_next      = '0;
                    qtr_next      = 2'd0;
                    bit_next      = 4'd0;
                    byte_next     = 1'b0;
                    rd_phase_next = 1'b0;
                    nack_next     = 1'b0;
                end
            end
            DONE: state_next = IDLE;
            default: begin
                div_next = tick ? '0 : div_reg + DIV_W'(1);
                if (tick) qtr_next = qtr_reg + 2'd1;
                // The last clock of q2 is the single sampling point of every slot.
                if (tick && qtr_reg == 2'd2) samp_next = sync_reg[1];
                if (slot_end) begin
                    case (state_reg)
                        START:  begin state_next = ID;  bit_next = 4'd0; end
                        RSTART: begin state_next = RID; bit_next = 4'd0; end
                        STOP: begin
                            if (rw_reg && !rd_phase_reg && !nack_reg) begin
                                state_next    = RSTART;
                                rd_phase_next = 1'b1;
                            end else begin
                                state_next = DONE;
                            end
                        end
                        default: begin
                            if (state_reg == RDATA && bit_reg != 4'd8)
                                rx_next = {rx_reg[6:0], samp_reg};
                            if (bit_reg != 4'd8) begin
                                bit_next = bit_reg + 4'd1;
                            end else begin
                                bit_next = 4'd0;
                                case (state_reg)
                                    ID: begin state_next = SUBADDR; byte_next = 1'b0; end
                                    SUBADDR: begin
                                        if (byte_reg != 1'(NBYTES - 1)) byte_next = 1'b1;
                                        else state_next = rw_reg ? STOP : WDATA;
                                    end
                                    WDATA: state_next = STOP;
                                    RID:   state_next = RDATA;
                                    RDATA: begin
                                        state_next   = STOP;
                                        rd_data_next = rx_reg;
                                    end
                                    default: ;
                                endcase
`ifdef SCCB_ACK_CHECK_EN
                                if (state_reg != RDATA && samp_reg) begin
                                    nack_next  = 1'b1;
                                    state_next = STOP;
                                end
`endif
                            end
                        end
                    endcase
                end
            end
        endcase

        // Bus levels are derived from the next state so the pins move with the slot boundary.
        tx_byte = 8'hFF;
        case (state_next)
            ID:      tx_byte = {id_reg, 1'b0};
            SUBADDR: tx_byte = (NBYTES == 2 && !byte_next) ? addr_reg[ADDR_W-1 -: 8] : addr_reg[7:0];
            WDATA:   tx_byte = wdat_reg;
            RID:     tx_byte = {id_reg, 1'b1};
            default: tx_byte = 8'hFF;
        endcase
        tx_bit = (bit_next == 4'd8) ? 1'b1 : tx_byte[3'd7 - bit_next[2:0]];

        c_next = 1'b1;
        d_next = 1'b1;
        case (state_next)
            START, RSTART: begin
                d_next = (qtr_next == 2'd0) || (qtr_next == 2'd1);
                c_next = (qtr_next != 2'd3);
            end
            STOP: begin
                d_next = (qtr_next == 2'd3);
                c_next = (qtr_next != 2'd0);
            end
            ID, SUBADDR, WDATA, RID, RDATA: begin
                c_next = qtr_next[1];
                d_next = tx_bit;
            end
            default: ;
        endcase

        busy_next = (state_next != IDLE) && (state_next != DONE);
        done_next = (state_next == DONE);
    end

    assign sio_c       = c_reg;
    assign sio_d       = d_reg ? 1'bz : 1'b0;
    assign cfg.rd_data = rd_data_reg;
    assign cfg.busy    = busy_reg;
    assign cfg.done    = done_reg;
`ifdef SCCB_ACK_CHECK_EN
    assign cfg.nack    = nack_reg;
`endif
endmodule

// File: tb/tb_sccb_master.sv
// Directed bench: two sccb_master instances (8- and 16-bit sub-address) on one shared SCCB bus
// with a decoding slave model that acknowledges written bytes and returns a read byte.
module tb_sccb_master;
    localparam logic [11:0] EV_START = 12'h400;
    localparam logic [11:0] EV_STOP  = 12'h800;

    logic clk;
    logic rst_n;
    wire  sio_c8, sio_c16;
    wire  sio_d;
    logic bus_c;

    int n_vec = 0;
    int n_err = 0;

    sccb_master_if #(.ADDR_W(8))  cfg8  ();
    sccb_master_if #(.ADDR_W(16)) cfg16 ();

    sccb_master #(.CLK_DIV(2), .ADDR_W(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .cfg(cfg8), .sio_c(sio_c8), .sio_d(sio_d)
    );
    sccb_master #(.CLK_DIV(2), .ADDR_W(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .cfg(cfg16), .sio_c(sio_c16), .sio_d(sio_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Idle master holds its clock high, so ANDing gives the active master's clock.
    assign bus_c = sio_c8 & sio_c16;

    logic slave_low = 1'b0;
    pullup (sio_d);
    assign sio_d = slave_low ? 1'b0 : 1'bz;

    // Bus decoder and slave model
    logic [11:0] ev[$];
    logic [11:0] exp_ev[$];
    logic [7:0]  slave_rd_byte = 8'h00;
    bit          nack_inject   = 1'b0;
    logic        prev_c = 1'b1, prev_d = 1'b1, mon_c, mon_d;
    logic [8:0]  sh = 9'd0;
    int          bitcnt = 0, frame_idx = 0, rd_idx = 0;
    bit          rd_active = 1'b0;

    always @(negedge clk) begin
        mon_c = bus_c;
        mon_d = (sio_d !== 1'b0);
        if (!rst_n) begin
            slave_low = 1'b0;
            rd_active = 1'b0;
            bitcnt    = 0;
        end else if (mon_c && prev_c && prev_d && !mon_d) begin
            ev.push_back(EV_START);
            bitcnt    = 0;
            frame_idx = 0;
        end else if (mon_c && prev_c && !prev_d && mon_d) begin
            ev.push_back(EV_STOP);
            bitcnt = 0;
        end else if (mon_c && !prev_c) begin
            sh = {sh[7:0], mon_d};
            bitcnt++;
            if (bitcnt == 9) begin
                ev.push_back({3'b000, sh});
                if (frame_idx == 0 && sh[1]) begin
                    rd_active = 1'b1;
                    rd_idx    = 0;
                end
                frame_idx++;
                bitcnt = 0;
            end
        end else if (!mon_c && prev_c) begin
            if (rd_active) begin
                if (rd_idx < 8) begin
                    slave_low = !slave_rd_byte[7 - rd_idx];
                    rd_idx++;
                end else begin
                    slave_low = 1'b0;
                    rd_active = 1'b0;
                end
            end else if (bitcnt == 8) begin
                slave_low = !(nack_inject && frame_idx == 0);
            end else begin
                slave_low = 1'b0;
            end
        end
        prev_c = mon_c;
        prev_d = mon_d;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] frame(input logic [7:0] b, input logic ninth);
        return {3'b000, b, ninth};
    endfunction

    task automatic cmp_events(input string tag);
        logic [11:0] got;
        chk({tag, "_nev"}, ev.size(), exp_ev.size());
        for (int i = 0; i < exp_ev.size(); i++) begin
            got = (i < ev.size()) ? ev[i] : 12'hFFF;
            chk($sformatf("%s_ev%0d", tag, i), got, exp_ev[i]);
        end
    endtask

    int          busy_cnt, done_cnt, post_busy;
    logic [7:0]  rd_at_done;

    task automatic run_txn(input bit sel, input bit rw, input logic [6:0] id,
                           input logic [15:0] addr, input logic [7:0] wd,
                           input int hold, input int pulse_at);
        bit   seen, st, b, d;
        int   after;
        ev.delete();
        busy_cnt = 0; done_cnt = 0; post_busy = 0; rd_at_done = 8'h00;
        seen = 1'b0; after = 0;
        @(negedge clk);
        if (sel) begin
            cfg16.rw = rw; cfg16.dev_id = id; cfg16.sub_addr = addr; cfg16.wr_data = wd; cfg16.start = 1'b1;
        end else begin
            cfg8.rw = rw; cfg8.dev_id = id; cfg8.sub_addr = addr[7:0]; cfg8.wr_data = wd; cfg8.start = 1'b1;
        end
        for (int cyc = 1; cyc <= 3000 && after < 20; cyc++) begin
            @(negedge clk);
            st = (cyc <= hold) || (cyc == pulse_at);
            if (sel) cfg16.start = st; else cfg8.start = st;
            b = sel ? cfg16.busy : cfg8.busy;
            d = sel ? cfg16.done : cfg8.done;
            if (seen) begin
                after++;
                if (b) post_busy++;
            end else if (b) begin
                busy_cnt++;
            end
            if (d) begin
                done_cnt++;
                seen = 1'b1;
                rd_at_done = sel ? cfg16.rd_data : cfg8.rd_data;
            end
        end
        if (sel) cfg16.start = 1'b0; else cfg8.start = 1'b0;
        $display("txn %s dut%0d id=%02h addr=%04h wd=%02h busy=%0d done=%0d rd=%02h events=%0d",
                 rw ? "RD" : "WR", sel ? 16 : 8, id, addr, wd, busy_cnt, done_cnt, rd_at_done, ev.size());
    endtask

    task automatic chk_bus_idle(input string tag);
        chk({tag, "_sioc"}, bus_c, 1'b1);
        chk({tag, "_siod"}, (sio_d === 1'b1), 1'b1);
    endtask

    initial begin
        rst_n = 1'b0;
        cfg8.start  = 1'b0; cfg8.rw  = 1'b0; cfg8.dev_id  = 7'd0; cfg8.sub_addr  = '0; cfg8.wr_data  = 8'd0;
        cfg16.start = 1'b0; cfg16.rw = 1'b0; cfg16.dev_id = 7'd0; cfg16.sub_addr = '0; cfg16.wr_data = 8'd0;
        repeat (3) @(negedge clk);
        chk("rst_busy8", cfg8.busy, 1'b0);
        chk("rst_done8", cfg8.done, 1'b0);
        chk("rst_rd8", cfg8.rd_data, 8'h00);
        chk("rst_busy16", cfg16.busy, 1'b0);
        chk("rst_rd16", cfg16.rd_data, 8'h00);
        chk("rst_sioc8", sio_c8, 1'b1);
        chk("rst_sioc16", sio_c16, 1'b1);
        chk("rst_siod", (sio_d === 1'b1), 1'b1);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // 8-bit write
        run_txn(1'b0, 1'b0, 7'h21, 16'h0012, 8'h80, 0, 0);
        chk("wr8_busy", busy_cnt, 232);
        chk("wr8_done", done_cnt, 1);
        chk("wr8_post", post_busy, 0);
        exp_ev = '{EV_START, frame(8'h42, 1'b0), frame(8'h12, 1'b0), frame(8'h80, 1'b0), EV_STOP};
        cmp_events("wr8");
        chk_bus_idle("wr8_idle");

        // 8-bit read, slave returns 0x76; master answers with NA=1
        slave_rd_byte = 8'h76;
        run_txn(1'b0, 1'b1, 7'h21, 16'h000A, 8'h00, 0, 0);
        chk("rd8_busy", busy_cnt, 320);
        chk("rd8_done", done_cnt, 1);
        chk("rd8_data", rd_at_done, 8'h76);
        exp_ev = '{EV_START, frame(8'h42, 1'b0), frame(8'h0A, 1'b0), EV_STOP,
                   EV_START, frame(8'h43, 1'b0), frame(8'h76, 1'b1), EV_STOP};
        cmp_events("rd8");

        // A write must leave the last read byte untouched
        run_txn(1'b0, 1'b0, 7'h3C, 16'h00FF, 8'h5A, 0, 0);
        chk("wr8b_busy", busy_cnt, 232);
        chk("wr8b_rdhold", cfg8.rd_data, 8'h76);
        exp_ev = '{EV_START, frame(8'h78, 1'b0), frame(8'hFF, 1'b0), frame(8'h5A, 1'b0), EV_STOP};
        cmp_events("wr8b");

        // Reset in the middle of the sub-address byte
        @(negedge clk);
        cfg8.rw = 1'b0; cfg8.dev_id = 7'h21; cfg8.sub_addr = 8'h55; cfg8.wr_data = 8'h11; cfg8.start = 1'b1;
        @(negedge clk);
        cfg8.start = 1'b0;
        repeat (99) @(negedge clk);
        chk("pre_rst_busy", cfg8.busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_sioc", sio_c8, 1'b1);
        chk("mid_rst_siod", (sio_d === 1'b1), 1'b1);
        chk("mid_rst_busy", cfg8.busy, 1'b0);
        chk("mid_rst_done", cfg8.done, 1'b0);
        chk("mid_rst_rd", cfg8.rd_data, 8'h00);
        $display("txn RST dut8 asserted during sub-address phase");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        run_txn(1'b0, 1'b0, 7'h21, 16'h0012, 8'h80, 0, 0);
        chk("after_rst_busy", busy_cnt, 232);
        chk("after_rst_done", done_cnt, 1);
        exp_ev = '{EV_START, frame(8'h42, 1'b0), frame(8'h12, 1'b0), frame(8'h80, 1'b0), EV_STOP};
        cmp_events("after_rst");

        // 16-bit address write, MSB byte first
        run_txn(1'b1, 1'b0, 7'h21, 16'h3008, 8'h02, 0, 0);
        chk("wr16_busy", busy_cnt, 304);
        chk("wr16_done", done_cnt, 1);
        exp_ev = '{EV_START, frame(8'h42, 1'b0), frame(8'h30, 1'b0), frame(8'h08, 1'b0),
                   frame(8'h02, 1'b0), EV_STOP};
        cmp_events("wr16");

        // 16-bit address read
        slave_rd_byte = 8'hA5;
        run_txn(1'b1, 1'b1, 7'h30, 16'h1234, 8'h00, 0, 0);
        chk("rd16_busy", busy_cnt, 392);
        chk("rd16_data", rd_at_done, 8'hA5);
        exp_ev = '{EV_START, frame(8'h60, 1'b0), frame(8'h12, 1'b0), frame(8'h34, 1'b0), EV_STOP,
                   EV_START, frame(8'h61, 1'b0), frame(8'hA5, 1'b1), EV_STOP};
        cmp_events("rd16");

        // start held for 100 cycles, then pulsed again while busy
        run_txn(1'b0, 1'b0, 7'h21, 16'h0012, 8'h80, 100, 150);
        chk("hold_busy", busy_cnt, 232);
        chk("hold_done", done_cnt, 1);
        chk("hold_post", post_busy, 0);
        exp_ev = '{EV_START, frame(8'h42, 1'b0), frame(8'h12, 1'b0), frame(8'h80, 1'b0), EV_STOP};
        cmp_events("hold");
        chk_bus_idle("hold_idle");

`ifdef SCCB_ACK_CHECK_EN
        // Slave refuses the ID byte: STOP follows immediately
        nack_inject = 1'b1;
        run_txn(1'b0, 1'b0, 7'h21, 16'h0012, 8'h80, 0, 0);
        nack_inject = 1'b0;
        chk("nack_busy", busy_cnt, 88);
        chk("nack_done", done_cnt, 1);
        chk("nack_flag", cfg8.nack, 1'b1);
        exp_ev = '{EV_START, frame(8'h42, 1'b1), EV_STOP};
        cmp_events("nack");
        run_txn(1'b0, 1'b0, 7'h21, 16'h0012, 8'h80, 0, 0);
        chk("nack_clear", cfg8.nack, 1'b0);
        chk("nack_clear_busy", busy_cnt, 232);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
